// File: rtl/pe_pkg.sv
// pe_pkg: shared encodings and helpers for the sequential MAC PE.
// Imported by pe_lane_mult and pe_seq_mac.
package pe_pkg;

   localparam int SM_W   = 8;
   localparam int MAG_W  = 7;
   localparam int PROD_W = 14;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      BIAS,
      OUT
   } state_e;

   function automatic int cnt_bits(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic logic signed [PROD_W:0] sm_to_twos(
      input logic              s,
      input logic [PROD_W-1:0] m
   );
      logic signed [PROD_W:0] v;
      v = signed'({1'b0, m});
      return s ? -v : v;
   endfunction

endpackage

// File: rtl/pe_lane_mult.sv
// pe_lane_mult: one sign-magnitude 7b x 7b multiplier lane.
// Output is two's complement; negative zero collapses to zero.
module pe_lane_mult
   import pe_pkg::*;
(
   input  logic [SM_W-1:0]        a,
   input  logic [SM_W-1:0]        b,
   output logic signed [PROD_W:0] p
);

   logic [PROD_W-1:0] mag;

   always_comb begin
      mag = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
      p   = sm_to_twos(a[SM_W-1] ^ b[SM_W-1], mag);
   end

endmodule

// File: rtl/pe_seq_mac.sv
// pe_seq_mac: sequential fully-connected PE (MAC, bias, shift, ReLU/sat).
// Build option: define PE_RELU_EN for the legacy ReLU (non-negative) output.
module pe_seq_mac
   import pe_pkg::*;
#(
   parameter int N_IN       = 62,
   parameter int LANES      = 2,
   parameter int ACC_W      = 21,
   parameter int SHIFT      = 9,
   parameter int BIAS_SCALE = 127
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SM_W-1:0]       bias,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*SM_W-1:0] in_data,
   input  logic [LANES*SM_W-1:0] weight,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SM_W-1:0]       out,
   output logic                  busy,
   output logic                  acc_sat
);

   localparam int BEATS = N_IN / LANES;
   localparam int CNT_W = cnt_bits(BEATS);
   localparam int PW    = PROD_W + 1;
   localparam int EXT_W = ACC_W + PROD_W + cnt_bits(LANES) + 2;
   localparam logic signed [EXT_W-1:0] AMAX =
      (EXT_W'(1) <<< (ACC_W - 1)) - EXT_W'(1);
   localparam logic signed [EXT_W-1:0] AMIN = -AMAX;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        drain_q, drain_d;
   logic                        pv_q, pv_d;
   logic [LANES-1:0][PW-1:0]    prod_q, prod_d;
   logic [LANES-1:0][PW-1:0]    prod_w;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic                        sat_q, sat_d;
   logic [SM_W-1:0]             bias_q, bias_d;
   logic [SM_W-1:0]             out_q, out_d;
   logic                        vld_q, vld_d;

   logic                        fire;
   logic signed [EXT_W-1:0]     lane_sum;
   logic signed [EXT_W-1:0]     acc_ext;
   logic signed [EXT_W-1:0]     acc_sum;
   logic signed [EXT_W-1:0]     bterm;
   logic signed [EXT_W-1:0]     bias_sum;
   logic signed [EXT_W-1:0]     fin;
   logic                        fin_sat;
   logic                        neg;
   logic [EXT_W-1:0]            mag;
   logic [EXT_W-1:0]            shf;
   logic [MAG_W-1:0]            m7;
   logic [SM_W-1:0]             res;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      pe_lane_mult u_mult (
         .a (in_data[SM_W*k +: SM_W]),
         .b (weight[SM_W*k +: SM_W]),
         .p (prod_w[k])
      );
   end

   // products are registered on accept; the accumulator trails by one beat
   assign in_ready  = (state_q == ACCUM) && !drain_q;
   assign fire      = in_valid && in_ready;
   assign out_valid = vld_q;
   assign out       = out_q;
   assign busy      = (state_q != IDLE);
   assign acc_sat   = sat_q;

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sum = lane_sum +
            {{(EXT_W-PW){prod_q[k][PW-1]}}, prod_q[k]};
      end
      acc_ext  = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
      acc_sum  = acc_ext + lane_sum;
      bterm    = EXT_W'(bias_q[MAG_W-1:0]) * EXT_W'(BIAS_SCALE);
      bias_sum = bias_q[SM_W-1] ? (acc_ext - bterm) : (acc_ext + bterm);

      fin     = bias_sum;
      fin_sat = 1'b0;
      if (bias_sum > AMAX) begin
         fin     = AMAX;
         fin_sat = 1'b1;
      end else if (bias_sum < AMIN) begin
         fin     = AMIN;
         fin_sat = 1'b1;
      end

      neg = (fin < 0);
      mag = neg ? -fin : fin;
      shf = mag >> SHIFT;
      m7  = (shf > EXT_W'(127)) ? 7'h7F : shf[MAG_W-1:0];
`ifdef PE_RELU_EN
      res = neg ? '0 : {1'b0, m7};
`else
      res = (m7 == '0) ? '0 : {neg, m7};
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      pv_d    = 1'b0;
      prod_d  = prod_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      bias_d  = bias_q;
      out_d   = out_q;
      vld_d   = vld_q;

      if (pv_q) begin
         if (acc_sum > AMAX) begin
            acc_d = AMAX[ACC_W-1:0];
            sat_d = 1'b1;
         end else if (acc_sum < AMIN) begin
            acc_d = AMIN[ACC_W-1:0];
            sat_d = 1'b1;
         end else begin
            acc_d = acc_sum[ACC_W-1:0];
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
               bias_d  = bias;
               acc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               drain_d = 1'b0;
            end
         end
         ACCUM: begin
            if (fire) begin
               prod_d = prod_w;
               pv_d   = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BEATS - 1)) drain_d = 1'b1;
            end
            if (drain_q) begin
               drain_d = 1'b0;
               state_d = BIAS;
            end
         end
         BIAS: begin
            out_d   = res;
            vld_d   = 1'b1;
            sat_d   = sat_q | fin_sat;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drain_q <= 1'b0;
         pv_q    <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         bias_q  <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         pv_q    <= pv_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         bias_q  <= bias_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
      end
   end

endmodule

// File: tb/tb_pe_seq_mac.sv
// tb_pe_seq_mac: directed bench for pe_seq_mac (N_IN=4, LANES=2).
// Second instance with ACC_W=16 exercises accumulator saturation.
module tb_pe_seq_mac;

   localparam int N_IN  = 4;
   localparam int LANES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bias = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [15:0] weight = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, busy, acc_sat;
   logic [7:0]  out;
   logic        s_in_ready, s_out_valid, s_busy, s_acc_sat;
   logic [7:0]  s_out;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pe_seq_mac #(.N_IN(N_IN), .LANES(LANES), .ACC_W(21)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .weight    (weight),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy),
      .acc_sat   (acc_sat)
   );

   pe_seq_mac #(.N_IN(N_IN), .LANES(LANES), .ACC_W(16)) u_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .in_data   (in_data),
      .weight    (weight),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out       (s_out),
      .busy      (s_busy),
      .acc_sat   (s_acc_sat)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input string tag, input logic [7:0] b,
                          input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] exp);
      int lat;
      start = 1'b1;
      bias  = b;
      tick;
      start = 1'b0;
      chk({tag, "_rdy"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = {a, a};
      weight   = {w, w};
      tick;
      tick;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_out"}, out, exp);
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic pop(input string tag);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({tag, "_pop_vld"}, out_valid, 0);
      chk({tag, "_pop_busy"}, busy, 0);
   endtask

   initial begin
      #12;
      chk("rst_rdy", in_ready, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat", acc_sat, 0);
      chk("rst_s_sat", s_acc_sat, 0);
      rst_n = 1'b1;
      tick;

      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("idle_inv_busy", busy, 0);
      chk("idle_inv_rdy", in_ready, 0);

      run_job("j7e", 8'h00, 8'h7F, 8'h7F, 8'h7E);
      chk("j7e_sat", acc_sat, 0);
      chk("sat16_out", s_out, 8'h3F);
      chk("sat16_flag", s_acc_sat, 1);
      chk("sat16_vld", s_out_valid, 1);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick;
         chk("bp_vld", out_valid, 1);
         chk("bp_out", out, 8'h7E);
         chk("bp_rdy", in_ready, 0);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      pop("bp");
      tick;
      chk("bp_idle_busy", busy, 0);

      start = 1'b1;
      bias  = 8'h7F;
      tick;
      start = 1'b0;
      chk("sat16_clr", s_acc_sat, 0);
      in_valid = 1'b1;
      in_data  = 16'h7F7F;
      weight   = 16'h7F7F;
      tick;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      chk("b7f_vld", out_valid, 1);
      chk("b7f_out", out, 8'h7F);
      pop("b7f");

      run_job("bff", 8'hFF, 8'h7F, 8'h7F, 8'h5E);
      pop("bff");

`ifdef PE_RELU_EN
      run_job("neg", 8'h00, 8'h7F, 8'hFF, 8'h00);
`else
      run_job("neg", 8'h00, 8'h7F, 8'hFF, 8'hFE);
`endif
      pop("neg");

      run_job("nz", 8'h00, 8'h80, 8'h7F, 8'h00);
      pop("nz");

      start = 1'b1;
      bias  = 8'h00;
      tick;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h7F7F;
      weight   = 16'h7F7F;
      tick;
      rst_n = 1'b0;
      #1;
      chk("abort_vld", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rdy", in_ready, 0);
      in_valid = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk("abort_idle", busy, 0);

      run_job("post", 8'h00, 8'h7F, 8'h7F, 8'h7E);
      pop("post");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
